// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// ALU operation codes and datapath mux selects.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b001;
    localparam logic [2:0] ALUOP_SUB   = 3'b010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch target out of DECODE; anything unrecognised traps.
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:     dispatch = S_RTEXEC;
            OP_LW, OP_SW: dispatch = S_MEMADR;
            OP_BEQ:       dispatch = S_BRANCH;
            OP_ADDI:      dispatch = S_ADDIEX;
            OP_J:         dispatch = S_JUMP;
            default:      dispatch = S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control decode: maps the current controller state (plus the
// zero flag and memory handshake where they qualify an output) to datapath controls.
module mc_output_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] aluop,
    output logic [1:0] pc_source,
    output logic       retire
);

    always_comb begin
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        aluop      = ALUOP_RTYPE;
        pc_source  = PCSRC_ALU;
        retire     = 1'b0;
        case (state_t'(state))
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                aluop     = ALUOP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                aluop     = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_ADD;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
            end
            S_RTEXEC: alu_src_a = 1'b1;
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = zero;
                retire    = 1'b1;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: state register, sticky illegal flag and
// retired-instruction counter; control decode lives in mc_output_decode.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 on mem_ready
// DECODE | dispatch on opcode, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | data read, wait for mem_ready
// MEMWB  | load result to register file
// MEMWR  | data write, wait for mem_ready
// RTEXEC | R-type ALU operation
// RTWB   | R-type result to rd
// BRANCH | beq compare, PC <= target when zero
// ADDIEX | addi ALU operation
// ADDIWB | addi result to rt
// JUMP   | PC <= jump target
// TRAP   | unsupported opcode, parked until reset
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       aluop,
    output logic [1:0]       pc_source,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state, state_nxt;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    logic       d_mem_req, d_mem_read, d_mem_write, d_i_or_d, d_ir_write, d_pc_write;
    logic       d_reg_write, d_reg_dst, d_mem_to_reg, d_alu_src_a, d_retire;
    logic [1:0] d_alu_src_b, d_pc_source;
    logic [2:0] d_aluop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_TRAP) illegal_q <= 1'b1;
            if (d_retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: state_nxt = dispatch(opcode);
            S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
            S_RTEXEC: state_nxt = S_RTWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_MEMWB, S_RTWB, S_BRANCH, S_ADDIWB, S_JUMP: state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state      (state),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (d_mem_req),
        .mem_read   (d_mem_read),
        .mem_write  (d_mem_write),
        .i_or_d     (d_i_or_d),
        .ir_write   (d_ir_write),
        .pc_write   (d_pc_write),
        .reg_write  (d_reg_write),
        .reg_dst    (d_reg_dst),
        .mem_to_reg (d_mem_to_reg),
        .alu_src_a  (d_alu_src_a),
        .alu_src_b  (d_alu_src_b),
        .aluop      (d_aluop),
        .pc_source  (d_pc_source),
        .retire     (d_retire)
    );

    // Reset forces every output low in the same cycle, ahead of the clock edge.
    assign mem_req     = d_mem_req    & ~rst;
    assign mem_read    = d_mem_read   & ~rst;
    assign mem_write   = d_mem_write  & ~rst;
    assign i_or_d      = d_i_or_d     & ~rst;
    assign ir_write    = d_ir_write   & ~rst;
    assign pc_write    = d_pc_write   & ~rst;
    assign reg_write   = d_reg_write  & ~rst;
    assign reg_dst     = d_reg_dst    & ~rst;
    assign mem_to_reg  = d_mem_to_reg & ~rst;
    assign alu_src_a   = d_alu_src_a  & ~rst;
    assign retire      = d_retire     & ~rst;
    assign illegal     = illegal_q    & ~rst;
    assign alu_src_b   = rst ? 2'b00 : d_alu_src_b;
    assign aluop       = rst ? 3'b000 : d_aluop;
    assign pc_source   = rst ? 2'b00 : d_pc_source;
    assign instr_count = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction cycle scripts push the
// expected control word each cycle, a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = 6'd0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic          reg_write, reg_dst, mem_to_reg, alu_src_a, retire, illegal;
    logic [1:0]    alu_src_b, pc_source;
    logic [2:0]    aluop;
    logic [CW-1:0] instr_count;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .aluop(aluop), .pc_source(pc_source), .retire(retire), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [18:0]   ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   retired = 0;

    // Control word: {mem_req,mem_read,mem_write,i_or_d,ir_write,pc_write,reg_write,
    //                reg_dst,mem_to_reg,alu_src_a,alu_src_b,aluop,pc_source,retire,illegal}
    function automatic logic [18:0] v(input logic mreq, mrd, mwr, iod, irw, pcw, rw, rdst, m2r,
                                      asa, input logic [1:0] asb, input logic [2:0] aop,
                                      input logic [1:0] pcs, input logic ret, ill);
        return {mreq, mrd, mwr, iod, irw, pcw, rw, rdst, m2r, asa, asb, aop, pcs, ret, ill};
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [18:0] act;
            e = q.pop_front();
            act = {mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
                   reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluop, pc_source, retire, illegal};
            n_tests++;
            if (act !== e.ctl || instr_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s t=%0t: ctl=%b count=%0d, expected ctl=%b count=%0d",
                         e.name, $time, act, instr_count, e.ctl, e.cnt);
            end
        end
    end

    task automatic cyc(input string name, input logic [18:0] c, input logic mr);
        exp_t e;
        mem_ready = mr;
        e.name = name;
        e.ctl  = c;
        e.cnt  = CW'(retired % (1 << CW));
        q.push_back(e);
        @(posedge clk);
        #1;
        if (c[1]) retired++;
    endtask

    task automatic rst_cycle(input logic mr);
        rst = 1'b1;
        retired = 0;
        cyc("reset", 19'd0, mr);
        rst = 1'b0;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fetch_decode(input int wf);
        for (int i = 0; i < wf; i++)
            cyc("fetch_wait", v(1,1,0,0,0,0,0,0,0,0,2'b01,3'b001,2'b00,0,0), 1'b0);
        cyc("fetch",  v(1,1,0,0,1,1,0,0,0,0,2'b01,3'b001,2'b00,0,0), 1'b1);
        cyc("decode", v(0,0,0,0,0,0,0,0,0,0,2'b11,3'b001,2'b00,0,0), rnd());
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wd, input logic z);
        opcode = op;
        zero   = z;
        fetch_decode(wf);
        case (op)
            6'b000000: begin
                cyc("rtexec", v(0,0,0,0,0,0,0,0,0,1,2'b00,3'b000,2'b00,0,0), rnd());
                cyc("rtwb",   v(0,0,0,0,0,0,1,1,0,0,2'b00,3'b000,2'b00,1,0), rnd());
            end
            6'b100011: begin
                cyc("lw_adr", v(0,0,0,0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0,0), rnd());
                for (int i = 0; i < wd; i++)
                    cyc("memrd_wait", v(1,1,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), 1'b0);
                cyc("memrd", v(1,1,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), 1'b1);
                cyc("memwb", v(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,1,0), rnd());
            end
            6'b101011: begin
                cyc("sw_adr", v(0,0,0,0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0,0), rnd());
                for (int i = 0; i < wd; i++)
                    cyc("memwr_wait", v(1,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), 1'b0);
                cyc("memwr", v(1,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,0), 1'b1);
            end
            6'b000100:
                cyc("branch", v(0,0,0,0,0,z,0,0,0,1,2'b00,3'b010,2'b01,1,0), rnd());
            6'b001000: begin
                cyc("addiex", v(0,0,0,0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0,0), rnd());
                cyc("addiwb", v(0,0,0,0,0,0,1,0,0,0,2'b00,3'b000,2'b00,1,0), rnd());
            end
            6'b000010:
                cyc("jump", v(0,0,0,0,0,1,0,0,0,0,2'b00,3'b000,2'b10,1,0), rnd());
            default: ;
        endcase
    endtask

    logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    initial begin
        @(posedge clk);
        #1;
        rst_cycle(1'b1);

        // R-type, zero-wait: retire in the 4th cycle, count 1 afterwards
        run_instr(6'b000000, 0, 0, 1'b0);
        // lw with a 3-cycle data wait
        run_instr(6'b100011, 0, 3, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b1);
        run_instr(6'b101011, 1, 2, 1'b1);
        run_instr(6'b001000, 2, 0, 1'b0);

        // Unsupported opcode parks in TRAP with illegal held
        opcode = 6'b111111;
        fetch_decode(0);
        for (int i = 0; i < 10; i++)
            cyc("trap", v(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1), rnd());
        rst_cycle(1'b0);

        // Reset during a store's memory wait abandons it without retiring
        opcode = 6'b101011;
        fetch_decode(0);
        cyc("sw_adr", v(0,0,0,0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0,0), 1'b0);
        cyc("memwr_wait", v(1,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), 1'b0);
        cyc("memwr_wait", v(1,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), 1'b0);
        rst_cycle(1'b1);
        run_instr(6'b001000, 0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                logic [5:0] bad;
                bad = 6'($urandom_range(0, 63));
                if (bad inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010})
                    bad = 6'b110011;
                opcode = bad;
                fetch_decode($urandom_range(0, 2));
                for (int i = 0; i < 3; i++)
                    cyc("trap", v(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1), rnd());
                rst_cycle(rnd());
            end else begin
                run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                          $urandom_range(0, 3), rnd());
            end
        end

        // Drive the counter to all-ones with jumps, then one more must wrap to 0
        while ((retired % (1 << CW)) != (1 << CW) - 1)
            run_instr(6'b000010, 0, 0, rnd());
        run_instr(6'b000010, 0, 0, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  6  instruction opcode field from instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory handshake completion, valid while mem_req=1.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_read / mem_write  output  1 each  access type qualifiers.
REQ-009 i_or_d  output  1  0=PC address, 1=ALUOut address.
REQ-010 ir_write / pc_write  output  1 each  load IR / load PC.
REQ-011 reg_write, reg_dst, mem_to_reg  output  1 each  register-file controls.
REQ-012 alu_src_a  output  1  0=PC, 1=register A.
REQ-013 alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-014 aluop  output  3  000=R-type (funct decoded downstream), 001=add, 010=sub.
REQ-015 pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-016 retire  output  1  one-cycle pulse on instruction completion.
REQ-017 illegal  output  1  sticky unsupported-opcode flag.
REQ-018 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-019 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP (4-bit encoding).
REQ-020 Outputs not listed for a state SHALL be 0; outputs are decoded from state, qualified by mem_ready/zero where stated.
REQ-021 FETCH: mem_req=1, mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, aluop=001, pc_source=00; ir_write=pc_write=mem_ready; stay until mem_ready=1, then DECODE.
REQ-022 DECODE: alu_src_a=0, alu_src_b=11, aluop=001; next by opcode: 000000->RTEXEC, 100011 or 101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other->TRAP.
REQ-023 MEMADR: alu_src_a=1, alu_src_b=10, aluop=001; ->MEMRD if opcode=100011, else MEMWR.
REQ-024 MEMRD: mem_req=1, mem_read=1, i_or_d=1; wait for mem_ready, then MEMWB.
REQ-025 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1; ->FETCH.
REQ-026 MEMWR: mem_req=1, mem_write=1, i_or_d=1; retire=mem_ready; on mem_ready ->FETCH.
REQ-027 RTEXEC: alu_src_a=1, alu_src_b=00, aluop=000; ->RTWB. RTWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1; ->FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=00, aluop=010, pc_source=01, pc_write=zero, retire=1; ->FETCH.
REQ-029 ADDIEX: alu_src_a=1, alu_src_b=10, aluop=001; ->ADDIWB. ADDIWB: reg_write=1, reg_dst=0, retire=1; ->FETCH.
REQ-030 JUMP: pc_source=10, pc_write=1, retire=1; ->FETCH.
REQ-031 TRAP: illegal=1, no writes, no mem_req; remain until rst.
REQ-032 instr_count SHALL increment by 1 in the cycle after each retire pulse and wrap from all-ones to 0.
REQ-033 Latency (mem_ready=1 immediately): R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
REQ-034 mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-035 While rst=1 all outputs SHALL be 0 (combinationally gated); on clock edge state<=FETCH, instr_count<=0, illegal<=0.
REQ-036 rst asserted mid-instruction, including during a memory wait, SHALL abandon it without retire or count increment.

Structure
REQ-037 Shared package SHALL hold state encoding, opcode constants, aluop codes, alu_src_b and pc_source codes.
REQ-038 One sub-module, mc_output_decode (combinational state/opcode-to-controls), SHALL be instantiated; state register and counter stay in multicycle_control.

Verification
REQ-039 rst 1 cycle, then opcode=000000, mem_ready=1 -> FETCH,DECODE,RTEXEC,RTWB; retire at cycle 4; instr_count=1.
REQ-040 lw (100011) with mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles, MEMWB once, mem_to_reg=1, 8 cycles total.
REQ-041 beq (000100) with zero=0 then zero=1 -> pc_write=0 then 1 in BRANCH, pc_source=01 both.
REQ-042 opcode=111111 -> TRAP, illegal=1 held 10 cycles, no writes; rst clears illegal to 0.
REQ-043 rst asserted in MEMWR wait -> next cycle state FETCH, instr_count unchanged, no retire.
REQ-044 instr_count preloaded via 65535 j instructions, one more -> wraps to 0.
